// File: rtl/spi_master_mode0_if.sv
// Word-stream handshake and SPI pin bundle for the mode-0 SPI master.
// master = the SPI master block, slave = whatever drives words and MISO.
interface spi_master_mode0_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             CS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  tx_data, tx_valid, MISO,
    output tx_ready, rx_data, rx_valid,
    output busy, CS_n, SCLK, MOSI
  );

  modport slave (
    output tx_data, tx_valid, MISO,
    input  tx_ready, rx_data, rx_valid,
    input  busy, CS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_master_mode0.sv
// SPI mode-0 master: word stream in, CS_n/SCLK/MOSI out, MISO captured
// into received words; back-to-back words share one CS_n assertion.
module spi_master_mode0 #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input logic                clk,
  input logic                rst,
  spi_master_mode0_if.master bus
);
  localparam int M1 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2 = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int BW = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_END,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;

  logic             tx_ready;
  logic             hs;
  logic [WIDTH-1:0] rx_next;

  assign tx_ready = !rst && (state_q == S_IDLE || state_q == S_END);
  assign hs       = bus.tx_valid && tx_ready;
  assign rx_next  = (rx_sr_q << 1) | WIDTH'(bus.MISO);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          mosi_d  = bus.tx_data[WIDTH-1];
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          rx_sr_d = rx_next;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          if (bit_q == BIT_LAST) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = S_END;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[WIDTH-2];
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        cnt_d = '0;
        if (hs) begin
          // burst: MSB goes out now, so LOW must not shift again
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          mosi_d  = bus.tx_data[WIDTH-1];
          bit_d   = '0;
          state_d = S_LOW;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.CS_n     = cs_n_q;
  assign bus.SCLK     = sclk_q;
  assign bus.MOSI     = mosi_q;
endmodule

// File: tb/tb_spi_master_mode0.sv
// Directed bench for spi_master_mode0: loopback, burst, echo slave,
// mid-transfer reset, gap timing and fast-divider timing.
module tb_spi_master_mode0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] mode = 2'd0;

  spi_master_mode0_if #(.WIDTH(8)) b1 ();
  spi_master_mode0_if #(.WIDTH(8)) b2 ();

  spi_master_mode0 #(
    .WIDTH(8), .CLK_DIV(4), .CS_SETUP(2),
    .CS_HOLD(2), .CS_GAP(2)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  spi_master_mode0 #(
    .WIDTH(8), .CLK_DIV(2), .CS_SETUP(2),
    .CS_HOLD(2), .CS_GAP(2)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  // echoing slave: replays last received word on the next CS
  logic       s_sclk_p, s_cs_p;
  logic [7:0] s_sh, s_cap, s_echo;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sclk_p <= 1'b0;
      s_cs_p   <= 1'b1;
      s_sh     <= 8'h00;
      s_cap    <= 8'h00;
      s_echo   <= 8'h00;
    end else begin
      s_sclk_p <= b1.SCLK;
      s_cs_p   <= b1.CS_n;
      if (s_cs_p && !b1.CS_n)
        s_sh <= s_echo;
      else if (!b1.CS_n && s_sclk_p && !b1.SCLK)
        s_sh <= s_sh << 1;
      if (!b1.CS_n && !s_sclk_p && b1.SCLK)
        s_cap <= {s_cap[6:0], b1.MOSI};
      if (!s_cs_p && b1.CS_n)
        s_echo <= s_cap;
    end
  end

  assign b1.MISO = (mode == 2'd0) ? b1.MOSI :
                   (mode == 2'd1) ? s_sh[7] : 1'b0;
  assign b2.MISO = 1'b1;

  int rises1 = 0, rxv1 = 0, csr1 = 0, viol1 = 0;
  int cs_low_n = 0, cs_high_n = 0, gap_meas = 0;
  int busy_low_n = 0, busy_gap = 0, setup_meas = 0;
  bit got_first = 1'b0;
  logic sclk1_p = 1'b0, cs1_p = 1'b1, busy1_p = 1'b0;
  logic [31:0] mosi_log = '0;
  logic [7:0] rx_last = '0, rx_prev = '0;

  always @(negedge clk) begin
    if (b1.CS_n) begin
      cs_high_n++;
      cs_low_n = 0;
      got_first = 1'b0;
      if (!cs1_p) csr1++;
    end else begin
      if (cs1_p) begin
        gap_meas = cs_high_n;
        cs_high_n = 0;
      end
      cs_low_n++;
    end
    if (b1.SCLK && !sclk1_p) begin
      rises1++;
      mosi_log = {mosi_log[30:0], b1.MOSI};
      if (!got_first) begin
        setup_meas = cs_low_n - 1;
        got_first = 1'b1;
      end
    end
    if (!b1.busy) begin
      busy_low_n++;
    end else begin
      if (!busy1_p) busy_gap = busy_low_n;
      busy_low_n = 0;
    end
    if (b1.rx_valid) begin
      rxv1++;
      rx_prev = rx_last;
      rx_last = b1.rx_data;
    end
    if (!rst && b1.tx_ready !== (!b1.busy || b1.rx_valid))
      viol1++;
    sclk1_p = b1.SCLK;
    cs1_p = b1.CS_n;
    busy1_p = b1.busy;
  end

  int rises2 = 0, rxv2 = 0, hi_n = 0, lo_n = 0, word_rises = 0;
  int hi_min = 99, hi_max = 0, lo_min = 99, lo_max = 0;
  logic sclk2_p = 1'b0;
  logic [7:0] rx2 = '0;

  always @(negedge clk) begin
    if (b2.SCLK && !sclk2_p) begin
      rises2++;
      if (word_rises > 0) begin
        if (lo_n < lo_min) lo_min = lo_n;
        if (lo_n > lo_max) lo_max = lo_n;
      end
      word_rises++;
      hi_n = 0;
    end
    if (!b2.SCLK && sclk2_p) begin
      if (hi_n < hi_min) hi_min = hi_n;
      if (hi_n > hi_max) hi_max = hi_n;
      lo_n = 0;
    end
    if (b2.SCLK) hi_n++;
    else lo_n++;
    if (b2.CS_n) word_rises = 0;
    if (b2.rx_valid) begin
      rxv2++;
      rx2 = b2.rx_data;
    end
    sclk2_p = b2.SCLK;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bit ok = 1'b0;
    b1.tx_data = d;
    b1.tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (b1.tx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 b1.tx_valid = 1'b0;
    check("hs_timeout", 32'(ok), 1);
    @(negedge clk);
  endtask

  task automatic wait_rx(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rxv1 >= target && !b1.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(ok), 1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int r0, v0, c0, w0;
  bit ok;

  initial begin
    b1.tx_valid = 1'b0;
    b1.tx_data  = 8'h00;
    b2.tx_valid = 1'b0;
    b2.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(b1.CS_n), 1);
    check("rst_sclk", 32'(b1.SCLK), 0);
    check("rst_mosi", 32'(b1.MOSI), 0);
    check("rst_rx_data", 32'(b1.rx_data), 0);
    check("rst_rx_valid", 32'(b1.rx_valid), 0);
    check("rst_busy", 32'(b1.busy), 0);
    check("rst_tx_ready", 32'(b1.tx_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx_ready", 32'(b1.tx_ready), 1);

    // single word, loopback
    mode = 2'd0;
    r0 = rises1;
    v0 = rxv1;
    send(8'hA5);
    wait_rx(v0 + 1);
    check("t1_rises", 32'(rises1 - r0), 8);
    check("t1_mosi_bits", {24'h0, mosi_log[7:0]}, 32'hA5);
    check("t1_setup", 32'(setup_meas), 2);
    check("t1_rx_valid_cnt", 32'(rxv1 - v0), 1);
    check("t1_rx_data", 32'(b1.rx_data), 32'hA5);

    // two-word burst with tx_valid held
    r0 = rises1;
    v0 = rxv1;
    c0 = csr1;
    w0 = viol1;
    b1.tx_data = 8'h3C;
    b1.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (b1.tx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 b1.tx_data = 8'hC3;
    check("t2_hs1", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b1.rx_valid && b1.tx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    #1 b1.tx_valid = 1'b0;
    check("t2_hs2", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rxv1 - v0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_done", 32'(ok), 1);
    check("t2_rises", 32'(rises1 - r0), 16);
    check("t2_cs_rise", 32'(csr1 - c0), 0);
    check("t2_rx_word0", 32'(rx_prev), 32'h3C);
    check("t2_rx_word1", 32'(rx_last), 32'hC3);
    wait_rx(v0 + 2);
    check("t2_rx_valid_cnt", 32'(rxv1 - v0), 2);
    check("t2_tx_ready_viol", 32'(viol1 - w0), 0);

    // reset after the 3rd rise aborts the word
    r0 = rises1;
    v0 = rxv1;
    send(8'hF0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rises1 - r0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_third_rise", 32'(ok), 1);
    rst = 1'b1;
    #1;
    check("t4_cs_n", 32'(b1.CS_n), 1);
    check("t4_sclk", 32'(b1.SCLK), 0);
    check("t4_busy", 32'(b1.busy), 0);
    check("t4_tx_ready", 32'(b1.tx_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4_no_rx_valid", 32'(rxv1 - v0), 0);
    send(8'h81);
    wait_rx(v0 + 1);
    check("t4_rx_data", 32'(b1.rx_data), 32'h81);

    // echo slave: second transfer returns the first word
    pulse_rst();
    mode = 2'd1;
    @(negedge clk);
    v0 = rxv1;
    send(8'h5A);
    wait_rx(v0 + 1);
    check("t3_first_rx", 32'(b1.rx_data), 32'h00);
    send(8'hFF);
    wait_rx(v0 + 2);
    check("t3_echo_rx", 32'(b1.rx_data), 32'h5A);

    // separate words back to back
    mode = 2'd0;
    v0 = rxv1;
    send(8'h11);
    wait_rx(v0 + 1);
    send(8'h22);
    wait_rx(v0 + 2);
    check("t5_cs_gap", 32'(gap_meas), 3);
    check("t5_busy_gap", 32'(busy_gap), 1);
    check("t5_rx_data", 32'(b1.rx_data), 32'h22);

    // CLK_DIV=2, MISO held high
    @(negedge clk);
    b2.tx_data = 8'h3A;
    b2.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (b2.tx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 b2.tx_valid = 1'b0;
    check("t6_hs", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rxv2 >= 1 && !b2.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_done", 32'(ok), 1);
    check("t6_rx_data", 32'(rx2), 32'hFF);
    check("t6_rises", 32'(rises2), 8);
    check("t6_hi_min", 32'(hi_min), 2);
    check("t6_hi_max", 32'(hi_max), 2);
    check("t6_lo_min", 32'(lo_min), 2);
    check("t6_lo_max", 32'(lo_max), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
